// File: rtl/rvlab_clkmgr_pkg.sv
// Shared types and helpers for the rvlab clock-enable / reset sequencer.
package rvlab_clkmgr_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } clkmgr_state_e;

  // One counter serves both the lock debounce and the release stagger.
  function automatic int clkmgr_cnt_w(input int stable_cycles, input int stagger);
    int m;
    m = (stable_cycles > stagger) ? stable_cycles : stagger;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rvlab_clken_div.sv
// Per-channel programmable clock-enable divider: one-cycle strobe every D+1 cycles while running.
module rvlab_clken_div
  import rvlab_clkmgr_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             clken_o
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_q;
  logic             clken_q;

  // The divisor is only sampled at wrap or while idle, so periods are never truncated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      div_q   <= '0;
      clken_q <= 1'b0;
    end else if (!run_i) begin
      cnt_q   <= '0;
      div_q   <= div_i;
      clken_q <= 1'b0;
    end else if (cnt_q == div_q) begin
      cnt_q   <= '0;
      div_q   <= div_i;
      clken_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_q + 1'b1;
      clken_q <= 1'b0;
    end
  end

  assign clken_o = clken_q;

endmodule

// File: rtl/rvlab_clken_mgr.sv
// MMCM lock qualifier, staggered per-domain reset release and divided clock-enable strobes.
// Optional lock-loss event counter is built when RVLAB_CLKMGR_LOSS_CNT_EN is defined.
//   state     | meaning
//   WAIT_LOCK | all domains in reset, waiting for synced lock
//   STABLE    | lock seen, debouncing for LOCK_STABLE_CYCLES
//   RELEASE   | releasing one channel every RST_STAGGER cycles
//   RUN       | all channels released, ready_o high
module rvlab_clken_mgr
  import rvlab_clkmgr_pkg::*;
#(
  parameter int NUM_CH             = 2,
  parameter int DIV_W              = 8,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_STAGGER        = 16,
  parameter int LOSS_CNT_W         = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    locked_i,
  input  logic [NUM_CH-1:0]       ch_en_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       clken_o,
  output logic [NUM_CH-1:0]       rst_no,
  output logic                    ready_o,
  output logic [LOSS_CNT_W-1:0]   lock_loss_cnt_o
);

  localparam int CNT_W = clkmgr_cnt_w(LOCK_STABLE_CYCLES, RST_STAGGER);
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(RST_STAGGER - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CH - 1);

  logic              sync1_q;
  logic              locked_s;
  clkmgr_state_e     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NUM_CH-1:0] rst_n_q;
  logic              ready_q;
  logic              lock_lost;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= locked_i;
      locked_s <= sync1_q;
    end
  end

  assign lock_lost = !locked_s && (state_q == RELEASE || state_q == RUN);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
    end else if (lock_lost) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        WAIT_LOCK: begin
          cnt_q <= '0;
          if (locked_s) state_q <= STABLE;
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q <= RELEASE;
            cnt_q   <= '0;
            idx_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == STAGGER_LAST) begin
            rst_n_q[idx_q] <= 1'b1;
            cnt_q          <= '0;
            if (idx_q == IDX_LAST) begin
              state_q <= RUN;
              ready_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RUN: begin
          cnt_q <= '0;
        end
        default: state_q <= WAIT_LOCK;
      endcase
    end
  end

`ifdef RVLAB_CLKMGR_LOSS_CNT_EN
  logic [LOSS_CNT_W-1:0] loss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      loss_cnt_q <= '0;
    end else if (lock_lost && (loss_cnt_q != {LOSS_CNT_W{1'b1}})) begin
      loss_cnt_q <= loss_cnt_q + 1'b1;
    end
  end

  assign lock_loss_cnt_o = loss_cnt_q;
`else
  assign lock_loss_cnt_o = '0;
`endif

  // locked_s gates the dividers so strobes stop on the same edge that collapses the resets.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rvlab_clken_div #(
      .DIV_W(DIV_W)
    ) u_div (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .run_i  (rst_n_q[k] & ch_en_i[k] & locked_s),
      .div_i  (div_i[k*DIV_W +: DIV_W]),
      .clken_o(clken_o[k])
    );
  end

  assign rst_no  = rst_n_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_rvlab_clken_mgr.sv
// Self-checking bench for rvlab_clken_mgr: lock debounce, staggered release, dividers, lock loss.
module tb_rvlab_clken_mgr;

  localparam int NUM_CH   = 3;
  localparam int DIV_W    = 8;
  localparam int LSC      = 16;
  localparam int RSS      = 4;
  localparam int LW       = 8;
  localparam int REL0     = LSC + RSS + 2;
  localparam int REL_LAST = REL0 + (NUM_CH - 1) * RSS;

`ifdef RVLAB_CLKMGR_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    locked;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*DIV_W-1:0] div;
  logic [NUM_CH-1:0]       clken;
  logic [NUM_CH-1:0]       rst_no;
  logic                    ready;
  logic [LW-1:0]           loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_loss = 0;

  typedef struct {
    int edge_n;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  pulse_q[$];

  rvlab_clken_mgr #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .LOCK_STABLE_CYCLES(LSC),
    .RST_STAGGER(RSS),
    .LOSS_CNT_W(LW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .locked_i       (locked),
    .ch_en_i        (ch_en),
    .div_i          (div),
    .clken_o        (clken),
    .rst_no         (rst_no),
    .ready_o        (ready),
    .lock_loss_cnt_o(loss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bump_loss();
    if (LOSS_EN && exp_loss < 255) exp_loss++;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    ch_en  = '0;
    div    = '0;
    #1;
    tick();
    tick();
    rst_n    = 1'b1;
    exp_loss = 0;
    exp_q.delete();
    pulse_q.delete();
  endtask

  // Expects locked already high; the next posedge is edge 0 (first sampling edge).
  task automatic watch_release(input string tag);
    logic [NUM_CH-1:0] prev;
    ev_t ev;
    exp_q.delete();
    for (int k = 0; k < NUM_CH; k++) exp_q.push_back('{REL0 + k * RSS, k});
    prev = rst_no;
    for (int e = 0; e < REL_LAST + 6; e++) begin
      tick();
      for (int k = 0; k < NUM_CH; k++) begin
        if (rst_no[k] && !prev[k]) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_rise: rst_no[%0d] rose at edge %0d, required no rise", tag, k, e);
          end else begin
            ev = exp_q.pop_front();
            if (ev.edge_n !== e || ev.ch !== k) begin
              n_fail++;
              $display("FAIL %s_rise: got ch%0d at edge %0d, required ch%0d at edge %0d",
                       tag, k, e, ev.ch, ev.edge_n);
            end
          end
        end
      end
      n_tests++;
      if (ready !== 1'(e >= REL_LAST)) begin
        n_fail++;
        $display("FAIL %s_ready: edge %0d got %b, required %b", tag, e, ready, (e >= REL_LAST));
      end
      prev = rst_no;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d channel releases never observed", tag, exp_q.size());
    end
    n_tests++;
    if (loss_cnt !== LW'(exp_loss)) begin
      n_fail++;
      $display("FAIL %s_loss_cnt: got %0d, required %0d", tag, loss_cnt, exp_loss);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    locked = 1'b0;
    ch_en  = '0;
    div    = '0;
    #3;
    n_tests += 4;
    if (rst_no !== 3'b000) begin n_fail++; $display("FAIL reset_rst_no: got %b, required 000", rst_no); end
    if (clken !== 3'b000) begin n_fail++; $display("FAIL reset_clken: got %b, required 000", clken); end
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", ready); end
    if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss_cnt: got %0d, required 0", loss_cnt); end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    n_tests++;
    if (rst_no !== 3'b000 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_lock: rst_no=%b ready=%b, required 000/0", rst_no, ready);
    end
  endtask

  task automatic test_power_up();
    do_reset();
    locked = 1'b1;
    watch_release("power_up");
  endtask

  task automatic test_debounce();
    do_reset();
    locked = 1'b1;
    repeat (10) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    watch_release("debounce");
  endtask

  task automatic test_divider();
    int p;
    do_reset();
    div    = {8'd2, 8'd3, 8'd0};
    ch_en  = 3'b111;
    locked = 1'b1;
    for (int t = REL0 + RSS + 4; t < 60; t += 4) pulse_q.push_back(t);
    for (int e = 0; e < 60; e++) begin
      tick();
      n_tests += 2;
      if (clken[0] !== 1'(e > REL0)) begin
        n_fail++;
        $display("FAIL div_d0: edge %0d got %b, required %b", e, clken[0], (e > REL0));
      end
      if (clken[2] !== 1'(e > REL_LAST && (e - REL_LAST) % 3 == 0)) begin
        n_fail++;
        $display("FAIL div_d2: edge %0d got %b", e, clken[2]);
      end
      if (clken[1]) begin
        n_tests++;
        if (pulse_q.size() == 0) begin
          n_fail++;
          $display("FAIL div_d3: unexpected pulse at edge %0d", e);
        end else begin
          p = pulse_q.pop_front();
          if (p !== e) begin
            n_fail++;
            $display("FAIL div_d3: pulse at edge %0d, required edge %0d", e, p);
          end
        end
      end
    end
    n_tests++;
    if (pulse_q.size() != 0) begin
      n_fail++;
      $display("FAIL div_d3_missing: %0d pulses not observed", pulse_q.size());
    end
  endtask

  // Runs straight after test_divider: RUN state, ch1 pulsing every 4 cycles.
  task automatic test_div_change();
    bit found;
    int p;
    found = 1'b0;
    for (int t = 0; t < 8 && !found; t++) begin
      tick();
      if (clken[1]) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL divchg_sync: no ch1 pulse within 8 cycles, required one");
    end else begin
      pulse_q.delete();
      pulse_q.push_back(4);
      pulse_q.push_back(6);
      pulse_q.push_back(8);
      pulse_q.push_back(10);
      tick();
      tick();
      div[15:8] = 8'd1;
      for (int r = 3; r <= 11; r++) begin
        tick();
        if (clken[1]) begin
          n_tests++;
          if (pulse_q.size() == 0) begin
            n_fail++;
            $display("FAIL divchg_pulse: unexpected pulse at +%0d", r);
          end else begin
            p = pulse_q.pop_front();
            if (p !== r) begin
              n_fail++;
              $display("FAIL divchg_pulse: pulse at +%0d, required +%0d", r, p);
            end
          end
        end
      end
      n_tests++;
      if (pulse_q.size() != 0) begin
        n_fail++;
        $display("FAIL divchg_missing: %0d pulses not observed", pulse_q.size());
      end
    end
  endtask

  // Runs in RUN with all channels enabled.
  task automatic test_lock_loss();
    locked = 1'b0;
    tick();
    tick();
    n_tests++;
    if (rst_no !== 3'b111) begin
      n_fail++;
      $display("FAIL loss_early: edge 1 rst_no=%b, required 111", rst_no);
    end
    tick();
    bump_loss();
    n_tests += 4;
    if (rst_no !== 3'b000) begin n_fail++; $display("FAIL loss_rst_no: got %b, required 000", rst_no); end
    if (clken !== 3'b000) begin n_fail++; $display("FAIL loss_clken: got %b, required 000", clken); end
    if (ready !== 1'b0) begin n_fail++; $display("FAIL loss_ready: got %b, required 0", ready); end
    if (loss_cnt !== LW'(exp_loss)) begin
      n_fail++;
      $display("FAIL loss_cnt_first: got %0d, required %0d", loss_cnt, exp_loss);
    end
  endtask

  task automatic test_loss_saturate();
    for (int i = 0; i < 300; i++) begin
      locked = 1'b1;
      for (int t = 0; t < REL0 + 8 && !rst_no[0]; t++) tick();
      n_tests++;
      if (!rst_no[0]) begin
        n_fail++;
        $display("FAIL sat_release_timeout: iteration %0d rst_no[0] never rose", i);
        break;
      end
      locked = 1'b0;
      tick();
      tick();
      tick();
      bump_loss();
      n_tests++;
      if (rst_no !== 3'b000) begin
        n_fail++;
        $display("FAIL sat_collapse: iteration %0d rst_no=%b, required 000", i, rst_no);
      end
    end
    n_tests++;
    if (loss_cnt !== LW'(exp_loss)) begin
      n_fail++;
      $display("FAIL sat_loss_cnt: got %0d, required %0d", loss_cnt, exp_loss);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    div    = {8'd2, 8'd3, 8'd0};
    ch_en  = 3'b111;
    locked = 1'b1;
    for (int t = 0; t < REL0 + 8 && !rst_no[0]; t++) tick();
    tick();
    n_tests++;
    if (clken[0] !== 1'b1 || rst_no !== 3'b001) begin
      n_fail++;
      $display("FAIL arst_pre: rst_no=%b clken0=%b, required 001/1", rst_no, clken[0]);
    end
    #2;
    rst_n = 1'b0;
    exp_loss = 0;
    #1;
    n_tests += 4;
    if (rst_no !== 3'b000) begin n_fail++; $display("FAIL arst_rst_no: got %b, required 000", rst_no); end
    if (clken !== 3'b000) begin n_fail++; $display("FAIL arst_clken: got %b, required 000", clken); end
    if (ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got %b, required 0", ready); end
    if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL arst_loss_cnt: got %0d, required 0", loss_cnt); end
    tick();
    rst_n = 1'b1;
    watch_release("arst_restart");
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_debounce();
    test_divider();
    test_div_change();
    test_lock_loss();
    test_loss_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvlab_clken_mgr.md
Name: rvlab_clken_mgr

Overview:
Parametrised clock-enable and reset sequencer that sits behind the FPGA MMCM in the rvlab clock tree, inside the single sys_clk domain.
- Qualifies the MMCM lock with a debounce window, then releases NUM_CH per-domain resets in staggered order.
- Generates one programmable divided clock-enable strobe per domain, so sub-blocks run at fractional rates without extra BUFGs.
- On lock loss, collapses all domains back into reset and counts the event.

Parameters:
NUM_CH, 2, number of enable/reset channels (>=1)
DIV_W, 8, width of each channel divisor
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release (>=1)
RST_STAGGER, 16, cycles between successive channel reset releases (>=1)
LOSS_CNT_W, 8, width of the saturating lock-loss counter

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
locked_i  in  1  MMCM lock, asynchronous to clk_i
ch_en_i  in  NUM_CH  per-channel strobe enable
div_i  in  NUM_CH*DIV_W  per-channel divisor D; channel k uses bits [k*DIV_W +: DIV_W]
clken_o  out  NUM_CH  per-channel one-cycle enable strobe
rst_no  out  NUM_CH  per-channel active-low domain reset
ready_o  out  1  high once all channels are released
lock_loss_cnt_o  out  LOSS_CNT_W  saturating lock-loss event count

Behaviour:
- Reset values:
  - clken_o=0, rst_no=0, ready_o=0, lock_loss_cnt_o=0.
  - State is WAIT_LOCK; all counters are 0.
- Lock synchroniser:
  - locked_i passes through a 2-flop synchroniser to produce locked_s.
  - Synchroniser flops reset to 0.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
- WAIT_LOCK:
  - Moves to STABLE when locked_s=1; stable count is cleared to 0.
- STABLE:
  - If locked_s=0: return to WAIT_LOCK, count cleared, no loss counted.
  - Otherwise count increments each cycle.
  - When count==LOCK_STABLE_CYCLES-1: move to RELEASE with stagger count=0 and channel index=0.
- RELEASE:
  - Stagger count increments each cycle.
  - When stagger count==RST_STAGGER-1: set rst_no[idx]=1, clear stagger count, idx++.
  - On the edge that releases channel NUM_CH-1: move to RUN and set ready_o=1 on that same edge.
- Release latency:
  - rst_no[0] rises LOCK_STABLE_CYCLES+RST_STAGGER+2 edges after the edge that first samples locked_i high.
  - Each following channel rises RST_STAGGER edges after the previous one.
- Lock loss (locked_s=0 in RELEASE or RUN), effective on the next edge:
  - rst_no=all 0, clken_o=0, ready_o=0, all counters cleared, state WAIT_LOCK.
  - lock_loss_cnt_o increments and saturates at all-ones.
- Channel divider (per channel k):
  - "Running" means rst_no[k]=1 and ch_en_i[k]=1; otherwise the counter is held at 0, clken_o[k]=0, and div_q[k] is loaded from div_i.
  - While running, each edge: if cnt==div_q then cnt<=0, clken_o[k]<=1, div_q<=div_i; else cnt++, clken_o[k]<=0.
- Divider consequences:
  - D=0 gives clken_o[k] continuously high.
  - D>0 gives a one-cycle pulse every D+1 cycles; the first pulse is registered D+1 edges after running starts.
  - Divisor changes take effect only at wrap; no short or long pulse is ever produced.
- ch_en_i deassert mid-period: the counter clears; re-enabling restarts a full D+1 period.
- rst_ni asserted mid-operation: all outputs return to reset values immediately (asynchronous).

Optional Feature:
Macro RVLAB_CLKMGR_LOSS_CNT_EN.
- Defined: the lock-loss counter is implemented as described above.
- Undefined: no counter flops; lock_loss_cnt_o is tied to 0. The port remains present, and all other behaviour is identical.

Decomposition:
- Package rvlab_clkmgr_pkg contains:
  - the state enum clkmgr_state_e {WAIT_LOCK, STABLE, RELEASE, RUN};
  - a helper function for counter width, $clog2 of max(LOCK_STABLE_CYCLES, RST_STAGGER).
- Sub-module rvlab_clken_div, instantiated NUM_CH times:
  - ports: clk_i, rst_ni, run_i, div_i[DIV_W], clken_o;
  - holds cnt and div_q.
- The top module holds the synchroniser, FSM, stagger logic and loss counter.

Test Plan:
All scenarios use NUM_CH=3, LOCK_STABLE_CYCLES=16, RST_STAGGER=4.
- Clean power-up: raise locked_i and hold -> rst_no[0] rises at edge 22, rst_no[1] at 26, rst_no[2] and ready_o at 30 (edges counted from the first sampling edge); lock_loss_cnt_o=0.
- Debounce: locked_i high for 10 cycles, low 1 cycle, then high -> no release before edge 22 counted from the final rise; lock_loss_cnt_o stays 0.
- Divider: D=0 on ch0, D=3 on ch1, ch_en_i=all 1 -> clken_o[0] high every cycle after release; clken_o[1] pulses every 4th cycle, first pulse 4 edges after rst_no[1] rises.
- Divisor change mid-period: ch1 D changes 3->1 two cycles after a pulse -> the next pulse arrives on the old 4-cycle spacing, then pulses every 2 cycles.
- Lock loss in RUN: drop locked_i -> 3 edges later rst_no=000, clken_o=000, ready_o=0, lock_loss_cnt_o=1. Repeat 300 times with LOSS_CNT_W=8 -> counter saturates at 255. Without the macro, the counter stays 0.
- Async reset during RELEASE: pull rst_ni low after rst_no[0] rises -> all outputs 0 immediately; after rst_ni release with locked_i high, the full 22/26/30 sequence repeats.
